// File: rtl/serdes_word_aligner.sv
// Word aligner behind the ISERDES. It issues BITSLIP until the training word repeats MATCH_COUNT times,
// then forwards the aligned words and optionally counts pattern errors.
//  state     | meaning
//  S_IDLE    | disabled, all outputs at reset values
//  S_COMPARE | checking din against the training word
//  S_SLIP    | one-cycle bitslip pulse to the ISERDES
//  S_WAIT    | ignore din while the ISERDES settles after a slip
//  S_LOCKED  | aligned, din forwarded to dout, errors counted
//  S_FAILED  | every rotation tried without lock, held until en drops
module serdes_word_aligner #(
    parameter int         DATA_WIDTH    = 8,
    parameter logic [7:0] TRAIN_PATTERN = 8'hB5,
    parameter int         MATCH_COUNT   = 16,
    parameter int         SLIP_WAIT     = 3
) (
    input  logic                  clkdiv,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  check,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  bitslip,
    output logic                  locked,
    output logic                  fail,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [3:0]            slip_cnt,
    output logic [15:0]           err_cnt
);

    localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_SLIP, S_WAIT, S_LOCKED, S_FAILED
    } state_t;

    state_t               state, state_nxt;
    logic [MATCH_W-1:0]   match_cnt, match_cnt_nxt;
    logic [WAIT_W-1:0]    wait_cnt, wait_cnt_nxt;
    logic [3:0]           slip_cnt_nxt;
    logic [15:0]          err_cnt_nxt;
    logic                 bitslip_nxt, locked_nxt, fail_nxt;
    logic [DATA_WIDTH-1:0] dout_nxt;
    logic                 match;

    assign match      = (din == TRAIN_PATTERN[DATA_WIDTH-1:0]);
    assign dout_valid = locked;

    always_ff @(posedge clkdiv or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            match_cnt <= '0;
            wait_cnt  <= '0;
            bitslip   <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
            dout      <= '0;
            slip_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            bitslip   <= bitslip_nxt;
            locked    <= locked_nxt;
            fail      <= fail_nxt;
            dout      <= dout_nxt;
            slip_cnt  <= slip_cnt_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

    // Dropping en wins over every other transition, including reaching lock.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_nxt = S_COMPARE;
                S_COMPARE: begin
                    if (match) begin
                        if (match_cnt == MATCH_W'(MATCH_COUNT - 1))
                            state_nxt = S_LOCKED;
                    end else if (slip_cnt == 4'(DATA_WIDTH)) begin
                        state_nxt = S_FAILED;
                    end else begin
                        state_nxt = S_SLIP;
                    end
                end
                S_SLIP:    state_nxt = S_WAIT;
                S_WAIT:    if (wait_cnt == WAIT_W'(1)) state_nxt = S_COMPARE;
                S_LOCKED:  state_nxt = S_LOCKED;
                S_FAILED:  state_nxt = S_FAILED;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        match_cnt_nxt = match_cnt;
        wait_cnt_nxt  = wait_cnt;
        slip_cnt_nxt  = slip_cnt;
        err_cnt_nxt   = err_cnt;
        bitslip_nxt   = (state_nxt == S_SLIP);
        locked_nxt    = (state_nxt == S_LOCKED);
        fail_nxt      = (state_nxt == S_FAILED);
        dout_nxt      = locked_nxt ? din : '0;
        if (state_nxt == S_IDLE) begin
            match_cnt_nxt = '0;
            wait_cnt_nxt  = '0;
            slip_cnt_nxt  = '0;
            err_cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    match_cnt_nxt = '0;
                    wait_cnt_nxt  = '0;
                    slip_cnt_nxt  = '0;
                    err_cnt_nxt   = '0;
                end
                S_COMPARE: begin
                    match_cnt_nxt = match ? match_cnt + MATCH_W'(1) : '0;
                    if (state_nxt == S_SLIP)
                        slip_cnt_nxt = slip_cnt + 4'd1;
                end
                S_SLIP:   wait_cnt_nxt = WAIT_W'(SLIP_WAIT);
                S_WAIT:   wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                S_LOCKED: begin
                    if (check && !match && err_cnt != 16'hFFFF)
                        err_cnt_nxt = err_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Bench for serdes_word_aligner: an ISERDES rotation model drives alignment trials, and a
// scoreboard checks the forwarded words and the error count once the block is locked.
module tb_serdes_word_aligner;

    localparam logic [7:0] PAT = 8'hB5;
    localparam int SLIP_WAIT   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        check = 1'b0;
    logic [7:0]  din_drv = PAT;
    logic [7:0]  din;
    logic        bitslip, locked, fail, dout_valid;
    logic [7:0]  dout;
    logic [3:0]  slip_cnt;
    logic [15:0] err_cnt;

    bit          use_model = 1'b0;
    int          rot_init = 0;
    int          base = 0;
    int          slips_total = 0;
    logic        slip_d1 = 1'b0;

    logic [7:0]  exp_q[$];
    bit          mon_active = 1'b0;
    int          errors = 0;
    int          checks = 0;

    serdes_word_aligner dut (
        .clkdiv(clk), .rst_n(rst_n), .en(en), .check(check), .din(din),
        .bitslip(bitslip), .locked(locked), .fail(fail), .dout(dout),
        .dout_valid(dout_valid), .slip_cnt(slip_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
        logic [15:0] t;
        t = {w, w} << n;
        return t[15:8];
    endfunction

    // ISERDES model: the word starts rotated by rot_init, and each slip undoes one bit two cycles later.
    assign din = use_model ? rotl8(PAT, (((rot_init - (slips_total - base)) % 8) + 8) % 8) : din_drv;

    always @(posedge clk) begin
        slip_d1 <= bitslip;
        if (slip_d1) slips_total <= slips_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always begin : monitor
        logic [7:0] e_word;
        @(posedge clk);
        #1;
        if (mon_active) begin
            checks++;
            if (dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL sb_valid: dout_valid=%0b required 1", dout_valid);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: dout=%0h with no expected word", dout);
            end else begin
                e_word = exp_q.pop_front();
                if (dout !== e_word) begin
                    errors++;
                    $display("FAIL sb_dout: dout=%0h required %0h", dout, e_word);
                end
            end
        end
    end

    // Steps until locked or fail; records edge count, bitslip pulse count, narrowest gap and widest pulse.
    task automatic run_until(input int budget, output int n, output int pulses,
                             output int min_gap, output int max_width);
        int  low_run, width;
        bit  prev;
        prev = 1'b0; low_run = 0; width = 0;
        pulses = 0; min_gap = 1000; max_width = 0; n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (bitslip) begin
                if (!prev) begin
                    if (pulses > 0 && low_run < min_gap) min_gap = low_run;
                    pulses++;
                    width = 0;
                end
                width++;
                if (width > max_width) max_width = width;
                low_run = 0;
            end else begin
                low_run++;
            end
            prev = bitslip;
            if (locked || fail) break;
        end
        if (!(locked || fail)) chk("wait_timeout", 32'(n), 32'(budget + 1));
    endtask

    // Drives words while locked; the reference forwards each word one cycle later and counts checked mismatches.
    task automatic sb_phase(input int nwords, input bit fixed);
        int         err_exp;
        logic [7:0] word;
        logic       chk_bit;
        err_exp = 0;
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            if (fixed) begin
                word    = (i == 2 || i == 5 || i == 6 || i == 11 || i == 17) ? 8'h00 : PAT;
                chk_bit = 1'b1;
            end else begin
                word    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : PAT;
                chk_bit = 1'($urandom);
            end
            use_model  = 1'b0;
            din_drv    = word;
            check      = chk_bit;
            exp_q.push_back(word);
            mon_active = 1'b1;
            if (chk_bit && word != PAT) err_exp++;
        end
        @(negedge clk);
        mon_active = 1'b0;
        check      = 1'b0;
        din_drv    = PAT;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("err_cnt", 32'(err_cnt), 32'(err_exp));
        chk("locked_hold", 32'(locked), 32'd1);
    endtask

    task automatic drop_en_and_check();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("en_drop_outputs", {bitslip, locked, fail, dout_valid, dout, slip_cnt, err_cnt}, 32'd0);
        @(negedge clk);
    endtask

    task automatic align_trial(input int r, input bit fixed_sb, input int nwords);
        int n, pulses, min_gap, max_width;
        @(negedge clk);
        din_drv   = PAT;
        use_model = 1'b1;
        rot_init  = r;
        base      = slips_total;
        en        = 1'b1;
        run_until(300, n, pulses, min_gap, max_width);
        chk("align_pulses", 32'(pulses), 32'(r));
        chk("align_slip_cnt", 32'(slip_cnt), 32'(r));
        chk("align_locked", 32'(locked), 32'd1);
        chk("align_edges", 32'(n), 32'(17 + r * (SLIP_WAIT + 2)));
        if (r > 0) chk("align_pulse_width", 32'(max_width), 32'd1);
        if (r > 1) chk("align_gap_ok", 32'(min_gap >= SLIP_WAIT + 1), 32'd1);
        sb_phase(nwords, fixed_sb);
        drop_en_and_check();
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, pulses, min_gap, max_width, seen;

        // Reset state
        #12;
        chk("reset_outputs", {bitslip, locked, fail, dout_valid, dout, slip_cnt, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {bitslip, locked, fail, dout_valid, dout, slip_cnt, err_cnt}, 32'd0);

        // Already aligned: lock after 1 + MATCH_COUNT edges, no slips
        din_drv = PAT;
        en = 1'b1;
        run_until(60, n, pulses, min_gap, max_width);
        chk("direct_edges", 32'(n), 32'd17);
        chk("direct_pulses", 32'(pulses), 32'd0);
        chk("direct_slip_cnt", 32'(slip_cnt), 32'd0);
        chk("direct_dout", 32'(dout), 32'(PAT));
        drop_en_and_check();

        // Rotated by 3, with five injected errors among training words
        align_trial(3, 1'b1, 20);

        // Random rotations and random locked traffic
        for (int t = 0; t < 4; t++)
            align_trial(int'($urandom_range(0, 7)), 1'b0, 30);

        // No training word ever: all 8 rotations, then fail
        @(negedge clk);
        use_model = 1'b0;
        din_drv = 8'h00;
        en = 1'b1;
        run_until(200, n, pulses, min_gap, max_width);
        chk("fail_flag", 32'(fail), 32'd1);
        chk("fail_locked", 32'(locked), 32'd0);
        chk("fail_pulses", 32'(pulses), 32'd8);
        chk("fail_slip_cnt", 32'(slip_cnt), 32'd8);
        chk("fail_edges", 32'(n), 32'(1 + 8 * (SLIP_WAIT + 2) + 1));
        @(posedge clk);
        #1;
        chk("fail_hold", {fail, bitslip}, 32'h2);
        drop_en_and_check();

        // en dropped mid-WAIT after the first slip
        en = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (bitslip) seen = 1;
        end
        chk("wait_first_pulse", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        chk("wait_bitslip_low", 32'(bitslip), 32'd0);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("wait_drop_slip_cnt", 32'(slip_cnt), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bitslip) seen++;
        end
        chk("wait_no_more_pulses", 32'(seen), 32'd0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_slip_cnt", 32'(slip_cnt), 32'd0);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (bitslip) seen = 1;
        end
        chk("restart_first_slip", 32'(slip_cnt), 32'd1);
        drop_en_and_check();

        // Lock, then saturate the error counter
        din_drv = PAT;
        en = 1'b1;
        run_until(60, n, pulses, min_gap, max_width);
        chk("relock_edges", 32'(n), 32'd17);
        @(negedge clk);
        din_drv = 8'h00;
        check = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("err_saturate", 32'(err_cnt), 32'h0000FFFF);
        chk("err_locked", 32'(locked), 32'd1);
        @(posedge clk);
        #1;
        chk("err_saturate_hold", 32'(err_cnt), 32'h0000FFFF);
        @(negedge clk);
        din_drv = PAT;
        check = 1'b0;

        // Asynchronous reset mid-cycle while locked
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {bitslip, locked, fail, dout_valid, dout, slip_cnt, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_until(60, n, pulses, min_gap, max_width);
        chk("post_reset_edges", 32'(n), 32'd17);
        chk("post_reset_locked", 32'(locked), 32'd1);
        chk("post_reset_err", 32'(err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serdes_word_aligner.md
Name: serdes_word_aligner

Overview:
- Word-alignment controller directly downstream of the deserializer in the SERDES test path.
- Consumes raw parallel words from the ISERDES (CLKDIV domain) and pulses BITSLIP until a known training word is seen repeatedly.
- Then declares lock and forwards aligned words to the test logic, optionally counting pattern errors.
- Also drives the ISERDES BITSLIP input, closing the loop.

Parameters:
- DATA_WIDTH, 8, deserialized word width (2..8).
- TRAIN_PATTERN, 8'hB5, expected training word; only the low DATA_WIDTH bits are used.
- MATCH_COUNT, 16, consecutive matching words required to lock (>=1).
- SLIP_WAIT, 3, CLKDIV cycles ignored after each BITSLIP pulse (>=1).

Ports:
- CLKDIV  input  1  the only clock; divided SERDES word clock.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  level; 1 = run alignment, 0 = return to IDLE.
- CHECK  input  1  in LOCKED, compare DIN to TRAIN_PATTERN and count errors.
- DIN  input  DATA_WIDTH  raw word from deserializer.
- BITSLIP  output  1  one-cycle slip request to ISERDES.
- LOCKED  output  1  alignment achieved.
- FAIL  output  1  all rotations tried without lock.
- DOUT  output  DATA_WIDTH  aligned word, registered.
- DOUT_VALID  output  1  DOUT valid; equals LOCKED.
- SLIP_CNT  output  4  BITSLIP pulses issued since alignment start.
- ERR_CNT  output  16  saturating mismatch count in LOCKED while CHECK=1.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low (RST_N). All outputs and internal state are registered.
- Reset values: BITSLIP=0, LOCKED=0, FAIL=0, DOUT=0, DOUT_VALID=0, SLIP_CNT=0, ERR_CNT=0, state=IDLE, match_cnt=0, wait_cnt=0.
- Match definition: a match is DIN == TRAIN_PATTERN[DATA_WIDTH-1:0], sampled on a rising edge.
- IDLE:
  - All outputs hold reset values.
  - EN=1 -> COMPARE next cycle; SLIP_CNT, ERR_CNT and match_cnt are cleared.
- COMPARE, on a match:
  - match_cnt increments.
  - When the increment makes match_cnt reach MATCH_COUNT -> LOCKED next cycle, so LOCKED rises one cycle after the MATCH_COUNT-th consecutive match.
- COMPARE, on a mismatch:
  - match_cnt is cleared.
  - If SLIP_CNT == DATA_WIDTH -> FAILED.
  - Otherwise -> SLIP.
- SLIP:
  - BITSLIP=1 for exactly this one cycle; SLIP_CNT increments.
  - Next state WAIT, with wait_cnt loaded to SLIP_WAIT.
- WAIT:
  - DIN is ignored and wait_cnt decrements.
  - At wait_cnt==1 -> COMPARE.
  - Consecutive BITSLIP pulses are therefore separated by at least SLIP_WAIT+1 low cycles.
- LOCKED:
  - LOCKED=1 and DOUT_VALID=1.
  - DOUT <= DIN every cycle (1-cycle latency).
  - If CHECK=1 and DIN is a mismatch, ERR_CNT increments and saturates at 16'hFFFF.
  - The block never leaves LOCKED on data errors.
- FAILED: FAIL=1, BITSLIP=0; the state is held until EN=0.
- EN=0 in any non-IDLE state:
  - Next cycle is IDLE, and all outputs return to reset values.
  - This also applies to an EN drop mid-SLIP or mid-WAIT: no further BITSLIP pulse is issued.
- Idle and unlocked outputs:
  - DOUT is 0 whenever not LOCKED.
  - BITSLIP is 0 in every state other than SLIP.
- Simultaneous events: EN=0 has priority over every transition, including reaching MATCH_COUNT.
- RST_N low at any time: immediate return to reset values, independent of the clock; operation resumes from IDLE after deassertion.

Test Plan:
1. DIN=8'hB5 constantly, EN rises -> zero BITSLIP pulses; LOCKED=1 exactly 17 cycles after EN is sampled high (1 IDLE->COMPARE cycle + 16 matches); SLIP_CNT=0.
2. Bench ISERDES model rotated by 3 bits, rotating one bit per BITSLIP with 2-cycle latency -> exactly 3 one-cycle BITSLIP pulses, each followed by >=4 low cycles; then LOCKED=1, SLIP_CNT=3, and DOUT equals DIN delayed one cycle.
3. DIN=8'h00 constantly -> 8 BITSLIP pulses, then FAIL=1, LOCKED=0, SLIP_CNT=8; EN=0 clears FAIL the next cycle.
4. Locked, CHECK=1, inject 5 words of 8'h00 among 8'hB5 -> ERR_CNT=5, LOCKED stays 1. Force ERR_CNT near 16'hFFFF -> it holds at 16'hFFFF.
5. EN dropped during WAIT after the first slip -> IDLE next cycle, BITSLIP never reasserts, SLIP_CNT=0. Re-raising EN restarts with counters cleared.
6. RST_N pulsed low asynchronously, mid-cycle, while LOCKED -> all outputs 0 immediately (before the next edge); alignment restarts from IDLE after release with EN=1.
